modbus_uart_rx: RTL and testbench

UART byte receiver feeding the Modbus RTU request parser. Synchronises the asynchronous serial line, finds start bits, samples data at mid-bit using a PRESCALER clocks-per-bit counter, checks optional parity and the stop bit, and presents each good byte as a one-cycle `rxv`/`rxd` strobe. Its `rxv`/`rxd` outputs connect directly to the parser's `rxv`/`rxd` inputs. The parser's inter-byte timeouts count in the same PRESCALER units.

---
 rtl/modbus_uart_rx_if.sv | 29 ++
 rtl/modbus_uart_rx.sv | 154 +++++++++++++++
 tb/tb_modbus_uart_rx.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_uart_rx_if.sv
// Serial line in, received-byte strobes and status out, for the Modbus UART receiver.
interface modbus_uart_rx_if;
   logic       rx_in;
   logic       rxv;
   logic [7:0] rxd;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   // Receiver side: samples the line, produces the byte strobes.
   modport master (
      input  rx_in,
      output rxv,
      output rxd,
      output frame_err,
      output parity_err,
      output busy
   );

   // Line driver / byte consumer side.
   modport slave (
      output rx_in,
      input  rxv,
      input  rxd,
      input  frame_err,
      input  parity_err,
      input  busy
   );
endinterface

// File: rtl/modbus_uart_rx.sv
// UART byte receiver for the Modbus RTU parser: 2-flop line synchroniser,
// mid-bit sampling with a PRESCALER clocks-per-bit counter, optional
// parity, stop-bit check, and a break state that swallows a held-low line.
module modbus_uart_rx #(
   parameter int PRESCALER = 100,
   parameter int PARITY    = 0
) (
   input  logic             clk,
   input  logic             rst,
   modbus_uart_rx_if.master bus
);
   localparam int              CW        = $clog2(PRESCALER);
   localparam logic [CW-1:0]   HALF_LAST = CW'(PRESCALER / 2 - 1);
   localparam logic [CW-1:0]   BIT_LAST  = CW'(PRESCALER - 1);
   localparam logic            PAR_EN    = (PARITY != 0);
   localparam logic            PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

   state_t          state, state_n;
   logic            sync1, rx_s;
   logic [CW-1:0]   bit_ctr, ctr_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      sh, sh_n;
   logic            pe, pe_n;
   logic            rxv_q, rxv_n;
   logic [7:0]      rxd_q, rxd_n;
   logic            ferr_q, ferr_n;
   logic            perr_q, perr_n;

   // Two-flop synchroniser for the asynchronous line; idles high out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= bus.rx_in;
         rx_s  <= sync1;
      end
   end

   // Receiver state, counters, shift register and registered output strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_ctr <= '0;
         idx     <= '0;
         sh      <= '0;
         pe      <= 1'b0;
         rxv_q   <= 1'b0;
         rxd_q   <= '0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         bit_ctr <= ctr_n;
         idx     <= idx_n;
         sh      <= sh_n;
         pe      <= pe_n;
         rxv_q   <= rxv_n;
         rxd_q   <= rxd_n;
         ferr_q  <= ferr_n;
         perr_q  <= perr_n;
      end
   end

   // Next-state logic: sample mid-bit, shift data LSB first, judge the frame at the stop bit.
   always_comb begin
      state_n = state;
      ctr_n   = bit_ctr;
      idx_n   = idx;
      sh_n    = sh;
      pe_n    = pe;
      rxd_n   = rxd_q;
      rxv_n   = 1'b0;
      ferr_n  = 1'b0;
      perr_n  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               ctr_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (bit_ctr == HALF_LAST) begin
               ctr_n = '0;
               if (!rx_s) begin
                  idx_n   = '0;
                  pe_n    = 1'b0;
                  state_n = DATA;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               ctr_n = bit_ctr + CW'(1);
            end
         end
         DATA: begin
            if (bit_ctr == BIT_LAST) begin
               ctr_n = '0;
               sh_n  = {rx_s, sh[7:1]};
               idx_n = idx + 3'd1;
               if (idx == 3'd7) begin
                  state_n = PAR_EN ? PAR : STOP;
               end
            end else begin
               ctr_n = bit_ctr + CW'(1);
            end
         end
         PAR: begin
            if (bit_ctr == BIT_LAST) begin
               ctr_n   = '0;
               pe_n    = ((^sh) ^ rx_s) != PAR_ODD;
               state_n = STOP;
            end else begin
               ctr_n = bit_ctr + CW'(1);
            end
         end
         STOP: begin
            if (bit_ctr == BIT_LAST) begin
               ctr_n = '0;
               pe_n  = 1'b0;
               if (rx_s) begin
                  if (pe) begin
                     perr_n = 1'b1;
                  end else begin
                     rxv_n = 1'b1;
                     rxd_n = sh;
                  end
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BRK;
               end
            end else begin
               ctr_n = bit_ctr + CW'(1);
            end
         end
         BRK: begin
            if (rx_s) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.rxv        = rxv_q;
   assign bus.rxd        = rxd_q;
   assign bus.frame_err  = ferr_q;
   assign bus.parity_err = perr_q;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_modbus_uart_rx.sv
// Self-checking bench for modbus_uart_rx: three receivers (no/odd/even parity)
// at PRESCALER=16, each on its own line, checked against a line-sampling model.
module tb_modbus_uart_rx;
   localparam int PS   = 16;
   localparam int LOGN = 20000;

   typedef logic lvq_t[$];
   typedef struct {
      int         cyc;
      int         kind;   // 0 = rxv, 1 = frame_err, 2 = parity_err
      logic [7:0] d;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_line [3];
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;
   int         multi_cnt = 0;
   ev_t        evq [3][$];
   logic       busy_log [3][LOGN];
   logic [7:0] last_good [3];

   logic       rxv_w [3];
   logic [7:0] rxd_w [3];
   logic       ferr_w [3];
   logic       perr_w [3];
   logic       busy_w [3];

   modbus_uart_rx_if bus0 ();
   modbus_uart_rx_if bus1 ();
   modbus_uart_rx_if bus2 ();

   assign bus0.rx_in = rx_line[0];
   assign bus1.rx_in = rx_line[1];
   assign bus2.rx_in = rx_line[2];

   assign rxv_w[0]  = bus0.rxv;        assign rxv_w[1]  = bus1.rxv;        assign rxv_w[2]  = bus2.rxv;
   assign rxd_w[0]  = bus0.rxd;        assign rxd_w[1]  = bus1.rxd;        assign rxd_w[2]  = bus2.rxd;
   assign ferr_w[0] = bus0.frame_err;  assign ferr_w[1] = bus1.frame_err;  assign ferr_w[2] = bus2.frame_err;
   assign perr_w[0] = bus0.parity_err; assign perr_w[1] = bus1.parity_err; assign perr_w[2] = bus2.parity_err;
   assign busy_w[0] = bus0.busy;       assign busy_w[1] = bus1.busy;       assign busy_w[2] = bus2.busy;

   modbus_uart_rx #(.PRESCALER(PS), .PARITY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   modbus_uart_rx #(.PRESCALER(PS), .PARITY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   modbus_uart_rx #(.PRESCALER(PS), .PARITY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   always #5 clk = ~clk;

   // Cycle counter; a value set #1 after a posedge is the cycle that edge started.
   always @(posedge clk) cyc <= cyc + 1;

   // Record strobes and busy history at the falling edge.
   always @(negedge clk) begin
      int  n;
      ev_t e;
      for (int ch = 0; ch < 3; ch++) begin
         if (cyc < LOGN) busy_log[ch][cyc] = busy_w[ch];
         n = int'(rxv_w[ch]) + int'(ferr_w[ch]) + int'(perr_w[ch]);
         if (n > 1) multi_cnt++;
         if (!rst) begin
            e.cyc = cyc;
            e.d   = rxd_w[ch];
            if (rxv_w[ch])  begin e.kind = 0; evq[ch].push_back(e); end
            if (ferr_w[ch]) begin e.kind = 1; evq[ch].push_back(e); end
            if (perr_w[ch]) begin e.kind = 2; evq[ch].push_back(e); end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Start of transmitted bit k, in clocks, for a bit period of per100/100 clocks.
   function automatic int edge_at(input int k, input int per100);
      return (k * per100) / 100;
   endfunction

   // Line level x clocks after the transmitter's start edge (idle high after the frame).
   function automatic logic line_at(input lvq_t lv, input int per100, input int x);
      for (int k = 0; k < lv.size(); k++)
         if (x >= edge_at(k, per100) && x < edge_at(k + 1, per100)) return lv[k];
      return 1'b1;
   endfunction

   task automatic build(input logic [7:0] b, input bit par_en, input logic pbit,
                        input logic stop, output lvq_t q);
      q = {};
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(b[i]);
      if (par_en) q.push_back(pbit);
      q.push_back(stop);
   endtask

   // Reference: the receiver sees the line 2 clocks late and samples it at
   // half a bit after the start edge, then every full bit.
   task automatic ref_rx(input lvq_t lv, input int per100, input int par_mode,
                         output int kind, output logic [7:0] d, output int at);
      int   ones, np;
      logic pbit, stop, pe;
      kind = -1;
      d    = '0;
      at   = 0;
      if (line_at(lv, per100, PS / 2) !== 1'b0) return;
      ones = 0;
      for (int k = 0; k < 8; k++) begin
         d[k] = line_at(lv, per100, PS / 2 + (k + 1) * PS);
         ones += int'(d[k]);
      end
      np = (par_mode != 0) ? 1 : 0;
      pe = 1'b0;
      if (np == 1) begin
         pbit = line_at(lv, per100, PS / 2 + 9 * PS);
         ones += int'(pbit);
         pe = (par_mode == 1) ? (ones % 2 == 0) : (ones % 2 != 0);
      end
      stop = line_at(lv, per100, PS / 2 + (9 + np) * PS);
      at   = 2 + PS / 2 + (9 + np) * PS + 1;
      if (!stop)   kind = 1;
      else if (pe) kind = 2;
      else         kind = 0;
   endtask

   task automatic send(input int ch, input lvq_t lv, input int per100, input bit b2b, output int n);
      if (!b2b) begin
         @(posedge clk);
         #1;
      end
      n = cyc;
      for (int k = 0; k < lv.size(); k++) begin
         rx_line[ch] = lv[k];
         repeat (edge_at(k + 1, per100) - edge_at(k, per100)) @(posedge clk);
         #1;
      end
      rx_line[ch] = 1'b1;
   endtask

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int ch = 0; ch < 3; ch++) begin
         checks++;
         if ({rxv_w[ch], ferr_w[ch], perr_w[ch], busy_w[ch]} !== 4'b0000 || rxd_w[ch] !== 8'h00) begin
            errors++;
            $display("FAIL reset ch%0d: rxv/ferr/perr/busy=%b%b%b%b rxd=%h, required 0000 rxd=00",
                     ch, rxv_w[ch], ferr_w[ch], perr_w[ch], busy_w[ch], rxd_w[ch]);
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      lvq_t a, b;
      int ka, kb, ata, atb, na, nb, lows;
      logic [7:0] da, db;
      build(8'h02, 1'b0, 1'b0, 1'b1, a);
      build(8'h03, 1'b0, 1'b0, 1'b1, b);
      ref_rx(a, 1600, 0, ka, da, ata);
      ref_rx(b, 1600, 0, kb, db, atb);
      send(0, a, 1600, 1'b0, na);
      send(0, b, 1600, 1'b1, nb);
      wait_cyc(nb + atb + 2);
      checks++;
      if (evq[0].size() != 2) begin
         errors++;
         $display("FAIL b2b count: %0d events, required 2", evq[0].size());
      end else begin
         checks++;
         if (evq[0][0].kind != ka || evq[0][0].d !== da || evq[0][0].cyc != na + ata) begin
            errors++;
            $display("FAIL b2b first: kind=%0d d=%h cyc=%0d, required kind=%0d d=%h cyc=%0d",
                     evq[0][0].kind, evq[0][0].d, evq[0][0].cyc, ka, da, na + ata);
         end
         checks++;
         if (evq[0][0].cyc - na != 155) begin
            errors++;
            $display("FAIL b2b latency: %0d clocks, required 155", evq[0][0].cyc - na);
         end
         checks++;
         if (evq[0][1].kind != kb || evq[0][1].d !== db || evq[0][1].cyc != nb + atb) begin
            errors++;
            $display("FAIL b2b second: kind=%0d d=%h cyc=%0d, required kind=%0d d=%h cyc=%0d",
                     evq[0][1].kind, evq[0][1].d, evq[0][1].cyc, kb, db, nb + atb);
         end
      end
      lows = 0;
      for (int c = na + ata; c <= nb + 2; c++) if (busy_log[0][c] === 1'b0) lows++;
      checks++;
      if (lows < 1 || busy_log[0][na + ata - 1] !== 1'b1) begin
         errors++;
         $display("FAIL b2b busy gap: low cycles=%0d busy@stop=%b, required >=1 and 1",
                  lows, busy_log[0][na + ata - 1]);
      end
      checks++;
      if (rxd_w[0] !== 8'h03) begin
         errors++;
         $display("FAIL b2b rxd hold: %h, required 03", rxd_w[0]);
      end
      last_good[0] = 8'h03;
      evq[0].delete();
   endtask

   task automatic test_parity();
      int         tch [8];
      logic [7:0] tby [8];
      logic       tpb [8];
      lvq_t       lv;
      int         kind, at, n;
      logic [7:0] d;
      tch = '{2, 2, 1, 1, 0, 0, 0, 0};
      tby = '{8'hA5, 8'hA5, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
      tpb = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 4; i < 8; i++) begin
         tch[i] = $urandom_range(1, 2);
         tby[i] = 8'($urandom_range(0, 255));
         tpb[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 8; i++) begin
         build(tby[i], 1'b1, tpb[i], 1'b1, lv);
         ref_rx(lv, 1600, tch[i], kind, d, at);
         send(tch[i], lv, 1600, 1'b0, n);
         wait_cyc(n + at + 2);
         checks++;
         if (evq[tch[i]].size() != 1) begin
            errors++;
            $display("FAIL parity[%0d] count: %0d events, required 1", i, evq[tch[i]].size());
         end else begin
            checks++;
            if (evq[tch[i]][0].kind != kind || evq[tch[i]][0].cyc != n + at) begin
               errors++;
               $display("FAIL parity[%0d] event: kind=%0d cyc=%0d, required kind=%0d cyc=%0d",
                        i, evq[tch[i]][0].kind, evq[tch[i]][0].cyc, kind, n + at);
            end
            checks++;
            if (kind == 0 && rxd_w[tch[i]] !== d) begin
               errors++;
               $display("FAIL parity[%0d] rxd: %h, required %h", i, rxd_w[tch[i]], d);
            end else if (kind != 0 && rxd_w[tch[i]] !== last_good[tch[i]]) begin
               errors++;
               $display("FAIL parity[%0d] rxd held: %h, required %h", i, rxd_w[tch[i]], last_good[tch[i]]);
            end
         end
         if (kind == 0) last_good[tch[i]] = d;
         evq[tch[i]].delete();
      end
   endtask

   task automatic test_break();
      lvq_t       lv;
      int         kind, at, n, nh, lows;
      logic [7:0] d;
      build(8'h55, 1'b0, 1'b0, 1'b0, lv);
      repeat (30) lv.push_back(1'b0);
      ref_rx(lv, 1600, 0, kind, d, at);
      send(0, lv, 1600, 1'b0, n);
      nh = n + edge_at(lv.size(), 1600);
      wait_cyc(nh + 5);
      checks++;
      if (evq[0].size() != 1 || kind != 1) begin
         errors++;
         $display("FAIL break count: %0d events (model kind %0d), required exactly one frame_err",
                  evq[0].size(), kind);
      end else begin
         checks++;
         if (evq[0][0].kind != 1 || evq[0][0].cyc != n + at) begin
            errors++;
            $display("FAIL break event: kind=%0d cyc=%0d, required kind=1 cyc=%0d",
                     evq[0][0].kind, evq[0][0].cyc, n + at);
         end
      end
      lows = 0;
      for (int c = n + 3; c <= nh + 2; c++) if (busy_log[0][c] !== 1'b1) lows++;
      checks++;
      if (lows != 0 || busy_log[0][nh + 3] !== 1'b0) begin
         errors++;
         $display("FAIL break busy: low cycles while held=%0d busy after release=%b, required 0 and 0",
                  lows, busy_log[0][nh + 3]);
      end
      checks++;
      if (rxd_w[0] !== last_good[0]) begin
         errors++;
         $display("FAIL break rxd held: %h, required %h", rxd_w[0], last_good[0]);
      end
      evq[0].delete();
      build(8'h7E, 1'b0, 1'b0, 1'b1, lv);
      ref_rx(lv, 1600, 0, kind, d, at);
      send(0, lv, 1600, 1'b0, n);
      wait_cyc(n + at + 2);
      checks++;
      if (evq[0].size() != 1 || evq[0][0].kind != 0 || evq[0][0].d !== 8'h7E || rxd_w[0] !== 8'h7E) begin
         errors++;
         $display("FAIL break recovery: %0d events rxd=%h, required one rxv with 7e", evq[0].size(), rxd_w[0]);
      end
      last_good[0] = 8'h7E;
      evq[0].delete();
   endtask

   task automatic test_glitch_and_abort();
      lvq_t lv;
      int   n, m, r;
      @(posedge clk);
      #1 rx_line[0] = 1'b0;
      n = cyc;
      repeat (5) @(posedge clk);
      #1 rx_line[0] = 1'b1;
      wait_cyc(n + 40);
      checks++;
      if (busy_log[0][n + 3] !== 1'b1 || busy_log[0][n + 2 + PS / 2 + 1] !== 1'b0) begin
         errors++;
         $display("FAIL glitch busy: during=%b after start sample=%b, required 1 and 0",
                  busy_log[0][n + 3], busy_log[0][n + 2 + PS / 2 + 1]);
      end
      checks++;
      if (evq[0].size() != 0) begin
         errors++;
         $display("FAIL glitch strobes: %0d events, required 0", evq[0].size());
      end
      evq[0].delete();
      build(8'hFF, 1'b0, 1'b0, 1'b1, lv);
      fork
         send(0, lv, 1600, 1'b0, n);
         begin
            @(negedge rx_line[0]);
            m = cyc;
            wait_cyc(m + 2 + PS / 2 + 5 * PS - 4);
            @(posedge clk);
            #1 rst = 1'b1;
            r = cyc;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            for (int ch = 0; ch < 3; ch++) begin
               checks++;
               if ({rxv_w[ch], ferr_w[ch], perr_w[ch], busy_w[ch]} !== 4'b0000 || rxd_w[ch] !== 8'h00) begin
                  errors++;
                  $display("FAIL abort reset ch%0d cyc %0d: rxv/ferr/perr/busy=%b%b%b%b rxd=%h, required 0000 rxd=00",
                           ch, r + 1, rxv_w[ch], ferr_w[ch], perr_w[ch], busy_w[ch], rxd_w[ch]);
               end
               last_good[ch] = 8'h00;
            end
         end
      join
      wait_cyc(n + 220);
      checks++;
      if (evq[0].size() != 0 || evq[1].size() != 0 || evq[2].size() != 0 || busy_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort strobes: events=%0d/%0d/%0d busy=%b, required 0/0/0 busy=0",
                  evq[0].size(), evq[1].size(), evq[2].size(), busy_w[0]);
      end
      for (int ch = 0; ch < 3; ch++) evq[ch].delete();
   endtask

   task automatic test_baud();
      int         per [4];
      lvq_t       lv;
      int         kind, at, n;
      logic [7:0] d;
      per = '{1500, 1700, 1536, 1664};
      for (int i = 0; i < 4; i++) begin
         build(8'h3C, 1'b0, 1'b0, 1'b1, lv);
         ref_rx(lv, per[i], 0, kind, d, at);
         send(0, lv, per[i], 1'b0, n);
         repeat (3 * PS) @(posedge clk);
         wait_cyc(n + at + 2);
         checks++;
         if (evq[0].size() != 1 || evq[0][0].kind != kind || evq[0][0].cyc != n + at) begin
            errors++;
            $display("FAIL baud %0d event: %0d events, required one of kind %0d at %0d",
                     per[i], evq[0].size(), kind, n + at);
         end else if (kind == 0) begin
            checks++;
            if (evq[0][0].d !== d) begin
               errors++;
               $display("FAIL baud %0d data: %h, required %h", per[i], evq[0][0].d, d);
            end
         end
         if (kind == 0) last_good[0] = d;
         checks++;
         if ((per[i] == 1536 || per[i] == 1664) && (kind != 0 || rxd_w[0] !== 8'h3C)) begin
            errors++;
            $display("FAIL baud %0d within tolerance: rxd=%h, required 3c", per[i], rxd_w[0]);
         end
         evq[0].delete();
      end
   endtask

   task automatic test_random();
      lvq_t       lv;
      int         ch, kind, at, n;
      logic [7:0] b, d;
      logic       pb, st;
      for (int i = 0; i < 12; i++) begin
         ch = $urandom_range(0, 2);
         b  = 8'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         st = ($urandom_range(0, 4) != 0);
         build(b, ch != 0, pb, st, lv);
         ref_rx(lv, 1600, ch, kind, d, at);
         send(ch, lv, 1600, 1'b0, n);
         wait_cyc(n + at + 2);
         checks++;
         if (evq[ch].size() != 1 || evq[ch][0].kind != kind || evq[ch][0].cyc != n + at) begin
            errors++;
            $display("FAIL random[%0d] ch%0d byte %h: %0d events, required one of kind %0d at %0d",
                     i, ch, b, evq[ch].size(), kind, n + at);
         end else begin
            checks++;
            if ((kind == 0 && rxd_w[ch] !== d) || (kind != 0 && rxd_w[ch] !== last_good[ch])) begin
               errors++;
               $display("FAIL random[%0d] ch%0d rxd: %h, required %h",
                        i, ch, rxd_w[ch], (kind == 0) ? d : last_good[ch]);
            end
         end
         if (kind == 0) last_good[ch] = d;
         evq[ch].delete();
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (multi_cnt != 0) begin
         errors++;
         $display("FAIL exclusive strobes: %0d cycles with several strobes, required 0", multi_cnt);
      end
   endtask

   initial begin
      for (int ch = 0; ch < 3; ch++) begin
         rx_line[ch]   = 1'b1;
         last_good[ch] = 8'h00;
      end
      test_reset();
      test_back_to_back();
      test_parity();
      test_break();
      test_glitch_and_abort();
      test_baud();
      test_random();
      test_exclusive();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
